// File: rtl/bus_xfer_sequencer_pkg.sv
// Shared definitions for the register-bus transfer sequencer: default geometry and FSM encoding.
package bus_xfer_sequencer_pkg;
  localparam int NUM_SRC_DEF = 13;
  localparam int DATA_W_DEF  = 16;
  localparam int SEL_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOAD   = 2'd2
  } state_t;
endpackage

// File: rtl/bus_req_fifo.sv
// Synchronous request FIFO with registered occupancy count; read data is the current head.
module bus_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/bus_xfer_sequencer.sv
// Sequences queued src->dst register transfers through the bus mux: select, settle, capture, load pulse.
module bus_xfer_sequencer
  import bus_xfer_sequencer_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SEL_W      = SEL_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEL_W-1:0]   req_src,
  input  logic [SEL_W-1:0]   req_dst,
  output logic [SEL_W-1:0]   mux_sel,
  input  logic [DATA_W-1:0]  bus_in,
  output logic [NUM_SRC-1:0] ld_en,
  output logic [DATA_W-1:0]  ld_data,
  output logic               done,
  output logic               err_illegal,
  output logic               busy
);
  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   dst_q, dst_d, mux_sel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_SRC-1:0] ld_en_d;
  logic [DATA_W-1:0]  ld_data_d;
  logic               done_d, err_d, busy_d;

  logic               push, pop, q_full, q_empty, head_ok;
  logic [QW-1:0]      q_count, q_cnt_nxt;
  logic [SEL_W-1:0]   hsrc, hdst;
  logic [2*SEL_W-1:0] q_rdata;

  // Ready comes from the registered count only: no pass-through when full.
  assign req_ready = !q_full;
  assign push      = req_valid && req_ready;
  assign {hsrc, hdst} = q_rdata;
  assign head_ok   = (int'(hsrc) < NUM_SRC) && (int'(hdst) < NUM_SRC);
  assign q_cnt_nxt = q_count + QW'(push) - QW'(pop);

  bus_req_fifo #(.W(2*SEL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({req_src, req_dst}),
    .pop   (pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    state_d   = state_q;
    mux_sel_d = mux_sel;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    ld_en_d   = '0;
    ld_data_d = ld_data;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        // LOAD pops directly so legal transfers run back to back.
        state_d = IDLE;
        if (!q_empty) begin
          pop = 1'b1;
          if (head_ok) begin
            mux_sel_d = hsrc;
            dst_d     = hdst;
            cnt_d     = CW'(SETTLE_CYC - 1);
            state_d   = SETTLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ld_data_d = bus_in;
          ld_en_d   = NUM_SRC'(1) << dst_q;
          done_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (q_cnt_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dst_q       <= '0;
      cnt_q       <= '0;
      mux_sel     <= '0;
      ld_en       <= '0;
      ld_data     <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      mux_sel     <= mux_sel_d;
      ld_en       <= ld_en_d;
      ld_data     <= ld_data_d;
      done        <= done_d;
      err_illegal <= err_d;
      busy        <= busy_d;
    end
  end
endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench: scoreboard of expected transfers plus table vectors and directed corner sequences.
module tb_bus_xfer_sequencer;
  logic        clk = 0;
  logic        rst_n = 0;
  always #5 clk = ~clk;

  // Main instance, SETTLE_CYC=1
  logic        req_valid = 0, req_ready;
  logic [3:0]  req_src = 0, req_dst = 0, mux_sel;
  logic [15:0] bus_in, ld_data;
  logic [12:0] ld_en;
  logic        done, err_illegal, busy;
  logic [15:0] regs [16];
  assign bus_in = (mux_sel < 4'd13) ? regs[mux_sel] : 16'h0;

  bus_xfer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .mux_sel(mux_sel), .bus_in(bus_in),
    .ld_en(ld_en), .ld_data(ld_data), .done(done), .err_illegal(err_illegal), .busy(busy));

  // Second instance, SETTLE_CYC=3, bus value tracks a free-running cycle counter
  logic        req_valid2 = 0, req_ready2;
  logic [3:0]  req_src2 = 0, req_dst2 = 0, mux_sel2;
  logic [15:0] bus_in2, ld_data2;
  logic [12:0] ld_en2;
  logic        done2, err2, busy2;
  logic [11:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 12'd1;
  assign bus_in2 = {mux_sel2, cyc};

  bus_xfer_sequencer #(.SETTLE_CYC(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_src(req_src2), .req_dst(req_dst2), .mux_sel(mux_sel2), .bus_in(bus_in2),
    .ld_en(ld_en2), .ld_data(ld_data2), .done(done2), .err_illegal(err2), .busy(busy2));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        legal;
    logic [3:0]  src;
    logic [12:0] en;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic        legal;
    logic [12:0] en;
  } vec_t;
  vec_t vecs[9];

  int   done_cyc[$];
  int   err_cnt = 0;
  int   ncyc = 0;
  logic saw_full = 0;
  logic [3:0] prev_mux = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (done || err_illegal || ld_en != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {done, err_illegal, ld_en}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.legal) begin
            chk("done", done, 1);
            chk("ld_en", ld_en, e.en);
            chk("ld_data", ld_data, e.data);
            chk("mux_sel_at_load", mux_sel, e.src);
            chk("err_on_legal", err_illegal, 0);
            done_cyc.push_back(ncyc);
          end else begin
            chk("err_illegal", err_illegal, 1);
            chk("ld_en_on_illegal", {done, ld_en}, 0);
            chk("mux_sel_held_on_illegal", mux_sel, prev_mux);
            err_cnt++;
          end
        end
      end
      prev_mux = mux_sel;
    end
  end

  function automatic exp_t mk(input logic [3:0] s, input logic [3:0] d);
    exp_t e;
    e.legal = (s < 4'd13) && (d < 4'd13);
    e.src   = s;
    e.en    = e.legal ? (13'd1 << d) : 13'd0;
    e.data  = e.legal ? regs[s] : 16'h0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with valid dropped.
  task automatic send(input logic [3:0] s, input logic [3:0] d, input logic [12:0] en);
    exp_t e;
    int   w;
    req_valid = 1; req_src = s; req_dst = d;
    w = 0;
    while (!req_ready && w < 40) begin
      saw_full = 1;
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    e = mk(s, d);
    e.en = en;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && !(sb.size() == 0 && !busy); i++) @(negedge clk);
    chk("drain_idle", {31'd0, (sb.size() == 0 && !busy)}, 1);
  endtask

  initial begin
    int   c1, c2, ec;
    logic bad;
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 * 16'(i) + 16'h0A5 + 16'(i);
    regs[3] = 16'hBEEF;
    vecs[0] = '{4'd3,  4'd7,  1'b1, 13'h0080};
    vecs[1] = '{4'd1,  4'd2,  1'b1, 13'h0004};
    vecs[2] = '{4'd4,  4'd5,  1'b1, 13'h0020};
    vecs[3] = '{4'd12, 4'd0,  1'b1, 13'h0001};
    vecs[4] = '{4'd13, 4'd2,  1'b0, 13'h0000};
    vecs[5] = '{4'd0,  4'd1,  1'b1, 13'h0002};
    vecs[6] = '{4'd5,  4'd5,  1'b1, 13'h0020};
    vecs[7] = '{4'd0,  4'd15, 1'b0, 13'h0000};
    vecs[8] = '{4'd12, 4'd12, 1'b1, 13'h1000};

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_ld_en", ld_en, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_done_err", {done, err_illegal}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);

    // Single transfer with exact latency
    send(4'd3, 4'd7, 13'h0080);
    chk("single_busy", busy, 1);
    @(negedge clk);
    chk("single_mux_sel_E1", mux_sel, 3);
    chk("single_no_load_E1", done, 0);
    @(negedge clk);
    chk("single_ld_en_E2", ld_en, 13'h0080);
    chk("single_ld_data_E2", ld_data, 16'hBEEF);
    chk("single_done_E2", done, 1);
    @(negedge clk);
    chk("single_done_drop", {done, ld_en}, 0);
    chk("single_busy_clear", busy, 0);
    chk("single_mux_sel_held", mux_sel, 3);

    // Table vectors, one at a time
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].src, vecs[i].dst, vecs[i].en);
      drain();
    end

    // Back-to-back: pulses exactly two cycles apart
    done_cyc.delete();
    send(4'd1, 4'd2, 13'h0004);
    send(4'd4, 4'd5, 13'h0020);
    send(4'd12, 4'd0, 13'h0001);
    drain();
    chk("b2b_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk("b2b_gap1", done_cyc[1] - done_cyc[0], 2);
      chk("b2b_gap2", done_cyc[2] - done_cyc[1], 2);
    end

    // Illegal head followed by a legal one
    ec = err_cnt;
    send(4'd13, 4'd2, 13'h0000);
    send(4'd0, 4'd1, 13'h0002);
    drain();
    chk("illegal_err_pulses", err_cnt - ec, 1);

    // Back-pressure: pushes outrun pops until the queue fills
    saw_full = 0;
    for (int i = 0; i < 10; i++) send(4'(i), 4'(12 - i), 13'd1 << (12 - i));
    chk("bp_ready_dropped", saw_full, 1);
    drain();

    // SETTLE_CYC=3: load three cycles after select, data from the last settle cycle
    req_valid2 = 1; req_src2 = 4'd3; req_dst2 = 4'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid2 = 0;
    c1 = -1; c2 = -1;
    for (int i = 0; i < 20 && c2 < 0; i++) begin
      if (c1 < 0 && mux_sel2 == 4'd3) c1 = int'(cyc);
      if (done2) c2 = int'(cyc);
      if (c2 < 0) @(negedge clk);
    end
    chk("s3_select_seen", {31'd0, c1 >= 0}, 1);
    chk("s3_latency", c2 - c1, 3);
    chk("s3_ld_en", ld_en2, 13'h0200);
    chk("s3_ld_data", ld_data2, {4'd3, 12'(c2 - 1)});
    @(negedge clk);
    chk("s3_done_drop", done2, 0);

    // Reset during SETTLE with two entries queued behind the in-flight transfer
    req_valid2 = 1; req_src2 = 4'd2; req_dst2 = 4'd3;
    @(posedge clk); @(negedge clk);
    req_src2 = 4'd4; req_dst2 = 4'd5;
    @(posedge clk); @(negedge clk);
    req_src2 = 4'd6; req_dst2 = 4'd7;
    @(posedge clk); @(negedge clk);
    req_valid2 = 0;
    chk("rm_in_settle_sel", mux_sel2, 2);
    chk("rm_no_load_yet", done2, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rm_mux_sel", mux_sel2, 0);
    chk("rm_req_ready", req_ready2, 1);
    chk("rm_busy", busy2, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done2 || ld_en2 != 0 || busy2) bad = 1;
    end
    chk("rm_flushed_quiet", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
